// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the multi-port byte-serial memory controller.
// Covers the length encoding, the FSM states and load-result extension.
package mem_port_pkg;

  localparam logic [1:0] LEN_BYTE   = 2'd0;
  localparam logic [1:0] LEN_HALF   = 2'd1;
  localparam logic [1:0] LEN_WORD   = 2'd2;
  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, IO_GAP} state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    case (sz)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    return 2'(byte_count(sz) - 3'd1);
  endfunction

  // len[2] selects sign extension from the top byte actually transferred
  function automatic logic [31:0] extend(input logic [2:0] len, input logic [31:0] d);
    case (len[1:0])
      LEN_BYTE: return {{24{len[2] & d[7]}}, d[7:0]};
      LEN_HALF: return {{16{len[2] & d[15]}}, d[15:0]};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        win,
  output logic                 any
);

  logic [PW-1:0] ptr;
  int            j;

  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        win      = PW'(j);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)          ptr <= '0;
    else if (en && any)  ptr <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Multi-requester byte-serial controller for the 8-bit external RAM bus:
// round-robin grant, per-port cancel, registered response, I/O gap cycle.
module mem_port_ctrl import mem_port_pkg::*; #(
  parameter int         NUM_PORTS = 2,
  parameter int         ADDR_W    = 32,
  parameter logic [1:0] IO_SEL    = IO_SEL_DEF
)(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS-1:0]    req_wr,
  input  logic [3*NUM_PORTS-1:0]  req_len,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]    req_cancel,
  output logic [NUM_PORTS-1:0]    req_grant,
  output logic [NUM_PORTS-1:0]    resp_valid,
  output logic [31:0]             resp_data,
  output logic                    busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                state;
  logic [PW-1:0]         owner;
  logic                  wr_q, io_q, mem_wr_q;
  logic [2:0]            len_q;
  logic [1:0]            cnt, last;
  logic [23:0]           wsh;
  logic [3:0][7:0]       rbuf, fin;

  logic [NUM_PORTS-1:0]  gnt_oh, owner_oh;
  logic [PW-1:0]         win;
  logic                  any;
  logic                  sel_wr, sel_io, cancel_hit;
  logic [2:0]            sel_len, eff_len;
  logic [ADDR_W-1:0]     sel_addr;
  logic [31:0]           sel_wdata;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in && state == IDLE),
    .req    (req_valid),
    .grant  (gnt_oh),
    .win    (win),
    .any    (any)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_oh[p]) begin
        sel_wr    = req_wr[p];
        sel_len   = req_len[3*p +: 3];
        sel_addr  = req_addr[ADDR_W*p +: ADDR_W];
        sel_wdata = req_wdata[32*p +: 32];
      end
    end
    sel_io  = (sel_addr[17:16] == IO_SEL);
    // I/O accesses always shrink to one byte but keep their extension mode
    eff_len = sel_io ? {sel_len[2], LEN_BYTE} : sel_len;

    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    cancel_hit      = !wr_q && (state == XFER || state == DRAIN) && req_cancel[owner];

    fin      = rbuf;
    fin[cnt] = mem_din;
  end

  assign mem_wr = mem_wr_q & rdy_in;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      owner      <= '0;
      wr_q       <= 1'b0;
      io_q       <= 1'b0;
      len_q      <= '0;
      cnt        <= '0;
      last       <= '0;
      wsh        <= '0;
      rbuf       <= '0;
      mem_wr_q   <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      req_grant  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (rdy_in) begin
      req_grant  <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: if (any) begin
          req_grant <= gnt_oh;
          owner     <= win;
          wr_q      <= sel_wr;
          io_q      <= sel_io;
          len_q     <= eff_len;
          cnt       <= '0;
          last      <= last_idx(eff_len[1:0]);
          rbuf      <= '0;
          mem_a     <= sel_addr;
          mem_wr_q  <= sel_wr;
          mem_dout  <= sel_wr ? sel_wdata[7:0]  : 8'h00;
          wsh       <= sel_wr ? sel_wdata[31:8] : 24'h0;
          state     <= XFER;
        end
        XFER: begin
          if (cancel_hit) begin
            mem_a    <= '0;
            mem_wr_q <= 1'b0;
            mem_dout <= '0;
            state    <= io_q ? IO_GAP : IDLE;
          end else begin
            // read data lags its address by one cycle
            if (cnt != 2'd0) rbuf[cnt - 2'd1] <= mem_din;
            if (cnt == last) begin
              mem_a    <= '0;
              mem_wr_q <= 1'b0;
              mem_dout <= '0;
              if (wr_q) begin
                resp_valid <= owner_oh;
                resp_data  <= '0;
                state      <= io_q ? IO_GAP : IDLE;
              end else begin
                state <= DRAIN;
              end
            end else begin
              cnt      <= cnt + 2'd1;
              mem_a    <= mem_a + 1'b1;
              mem_dout <= wsh[7:0];
              wsh      <= wsh >> 8;
            end
          end
        end
        DRAIN: begin
          if (!cancel_hit) begin
            resp_data  <= extend(len_q, fin);
            resp_valid <= owner_oh;
          end
          state <= io_q ? IO_GAP : IDLE;
        end
        IO_GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_port_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  req_valid, req_wr, req_cancel, req_grant, resp_valid;
  logic [5:0]  req_len;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] resp_data;
  logic        busy;
  logic [7:0]  ram [0:255];

  int n_chk  = 0;
  int n_fail = 0;
  int order[$];
  int gcnt[2];
  int rcnt[2];

  mem_port_ctrl #(.NUM_PORTS(2), .ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req_valid(req_valid), .req_wr(req_wr), .req_len(req_len),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_cancel(req_cancel),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // RAM answers the address of the previous cycle
  always @(posedge clk_in or posedge rst_in)
    if (rst_in) mem_din <= 8'h00;
    else        mem_din <= ram[mem_a[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic set_port(input int p, input logic wr, input logic [2:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata);
    req_wr[p]             = wr;
    req_len[3*p +: 3]     = len;
    req_addr[32*p +: 32]  = addr;
    req_wdata[32*p +: 32] = wdata;
    req_valid[p]          = 1'b1;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    req_valid = '0; req_wr = '0; req_cancel = '0;
    req_len = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    ram[4] = 8'h55; ram[5] = 8'h80; ram[6] = 8'h66; ram[7] = 8'h77;
    ram[8'h10] = 8'h7F;

    // reset state
    cyc(); cyc();
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", 32'(busy), 0);
    rst_in = 1'b0;

    // port0 word load at 0x100
    set_port(0, 1'b0, 3'b110, 32'h100, 32'h0);
    cyc(); chk("w_grant", 32'(req_grant), 32'b01); chk("w_a0", mem_a, 32'h100);
    chk("w_wr0", 32'(mem_wr), 0); chk("w_busy", 32'(busy), 1);
    req_valid[0] = 1'b0;
    cyc(); chk("w_a1", mem_a, 32'h101); chk("w_grant_pulse", 32'(req_grant), 0);
    cyc(); chk("w_a2", mem_a, 32'h102);
    cyc(); chk("w_a3", mem_a, 32'h103);
    cyc(); chk("w_drain_a", mem_a, 0); chk("w_drain_rv", 32'(resp_valid), 0);
    cyc(); chk("w_rv", 32'(resp_valid), 32'b01); chk("w_data", resp_data, 32'h44332211);
    chk("w_idle", 32'(busy), 0);

    // port1 signed then unsigned byte load of 0x80
    set_port(1, 1'b0, 3'b100, 32'h105, 32'h0);
    cyc(); chk("sb_grant", 32'(req_grant), 32'b10); chk("sb_a", mem_a, 32'h105);
    req_valid[1] = 1'b0;
    cyc(); chk("sb_drain_a", mem_a, 0);
    cyc(); chk("sb_rv", 32'(resp_valid), 32'b10); chk("sb_data", resp_data, 32'hFFFFFF80);
    set_port(1, 1'b0, 3'b000, 32'h105, 32'h0);
    cyc(); req_valid[1] = 1'b0;
    cyc();
    cyc(); chk("ub_rv", 32'(resp_valid), 32'b10); chk("ub_data", resp_data, 32'h00000080);

    // both ports request continuously, two word loads each
    set_port(0, 1'b0, 3'b010, 32'h100, 32'h0);
    set_port(1, 1'b0, 3'b010, 32'h104, 32'h0);
    gcnt[0] = 0; gcnt[1] = 0; rcnt[0] = 0; rcnt[1] = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      for (int p = 0; p < 2; p++) begin
        if (req_grant[p]) begin
          order.push_back(p);
          gcnt[p]++;
          if (gcnt[p] == 2) req_valid[p] = 1'b0;
        end
        if (resp_valid[p]) rcnt[p]++;
      end
    end
    chk("rr_ngrants", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : 99, i % 2);
    chk("rr_resp0", rcnt[0], 2);
    chk("rr_resp1", rcnt[1], 2);

    // port0 half store 0xBEEF to 0x20
    set_port(0, 1'b1, 3'b001, 32'h20, 32'h0000BEEF);
    cyc(); chk("hs_grant", 32'(req_grant), 32'b01); chk("hs_a0", mem_a, 32'h20);
    chk("hs_wr0", 32'(mem_wr), 1); chk("hs_d0", 32'(mem_dout), 32'hEF);
    req_valid[0] = 1'b0; req_wr[0] = 1'b0;
    cyc(); chk("hs_a1", mem_a, 32'h21); chk("hs_wr1", 32'(mem_wr), 1);
    chk("hs_d1", 32'(mem_dout), 32'hBE);
    cyc(); chk("hs_rv", 32'(resp_valid), 32'b01); chk("hs_data", resp_data, 0);
    chk("hs_wr_end", 32'(mem_wr), 0); chk("hs_a_end", mem_a, 0);

    // I/O word load shrinks to one byte, then a gap cycle delays the next grant
    ram[0] = 8'h5A;
    set_port(0, 1'b0, 3'b010, 32'h30000, 32'h0);
    cyc(); chk("io_grant", 32'(req_grant), 32'b01); chk("io_a", mem_a, 32'h30000);
    req_valid[0] = 1'b0;
    cyc(); chk("io_drain_a", mem_a, 0); chk("io_busy", 32'(busy), 1);
    set_port(1, 1'b0, 3'b000, 32'h10, 32'h0);
    cyc(); chk("io_rv", 32'(resp_valid), 32'b01); chk("io_data", resp_data, 32'h5A);
    chk("io_gap_busy", 32'(busy), 1); chk("io_gap_a", mem_a, 0);
    chk("io_gap_nogrant", 32'(req_grant), 0);
    cyc(); chk("io_idle_nogrant", 32'(req_grant), 0); chk("io_idle", 32'(busy), 0);
    cyc(); chk("io_next_grant", 32'(req_grant), 32'b10); chk("io_next_a", mem_a, 32'h10);
    req_valid[1] = 1'b0;
    cyc();
    cyc(); chk("io_next_rv", 32'(resp_valid), 32'b10); chk("io_next_data", resp_data, 32'h7F);

    // cancel port0 load after byte1; port1 store then runs with an rdy_in stall
    set_port(0, 1'b0, 3'b010, 32'h100, 32'h0);
    set_port(1, 1'b1, 3'b010, 32'h40, 32'hA1B2C3D4);
    cyc(); chk("cx_grant", 32'(req_grant), 32'b01); chk("cx_a0", mem_a, 32'h100);
    req_valid[0] = 1'b0;
    cyc(); chk("cx_a1", mem_a, 32'h101);
    req_cancel[0] = 1'b1;
    cyc(); chk("cx_a_drop", mem_a, 0); chk("cx_no_rv", 32'(resp_valid), 0);
    chk("cx_idle", 32'(busy), 0);
    req_cancel[0] = 1'b0;
    cyc(); chk("st_grant", 32'(req_grant), 32'b10); chk("st_a0", mem_a, 32'h40);
    chk("st_wr0", 32'(mem_wr), 1); chk("st_d0", 32'(mem_dout), 32'hD4);
    chk("cx_no_late_rv", 32'(resp_valid), 0);
    req_valid[1] = 1'b0; req_wr[1] = 1'b0;
    cyc(); chk("st_a1", mem_a, 32'h41); chk("st_d1", 32'(mem_dout), 32'hC3);
    rdy_in = 1'b0;
    #1 chk("stall_wr_gate", 32'(mem_wr), 0);
    for (int s = 0; s < 3; s++) begin
      cyc(); chk($sformatf("stall%0d_a", s), mem_a, 32'h41);
      chk($sformatf("stall%0d_wr", s), 32'(mem_wr), 0);
      chk($sformatf("stall%0d_d", s), 32'(mem_dout), 32'hC3);
    end
    rdy_in = 1'b1;
    #1 chk("resume_wr", 32'(mem_wr), 1);
    req_cancel[1] = 1'b1;
    cyc(); chk("st_a2", mem_a, 32'h42); chk("st_d2", 32'(mem_dout), 32'hB2);
    cyc(); chk("st_a3", mem_a, 32'h43); chk("st_d3", 32'(mem_dout), 32'hA1);
    req_cancel[1] = 1'b0;
    cyc(); chk("st_rv", 32'(resp_valid), 32'b10); chk("st_wr_end", 32'(mem_wr), 0);
    chk("st_a_end", mem_a, 0);

    // reset mid-transfer abandons the access
    set_port(0, 1'b0, 3'b010, 32'h100, 32'h0);
    cyc(); chk("rm_grant", 32'(req_grant), 32'b01);
    req_valid[0] = 1'b0;
    cyc(); rst_in = 1'b1;
    #1 chk("rm_a", mem_a, 0); chk("rm_busy", 32'(busy), 0);
    cyc(); rst_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc(); chk($sformatf("rm_no_rv%0d", c), 32'(resp_valid), 0);
    end
    chk("rm_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
